multicycle_datapath: RTL and testbench
======================================

Name: multicycle_datapath

Overview:
Parametrised multi-cycle RV32I-subset core: datapath plus internal sequencer FSM.
Replaces separate instruction/data ports with one unified memory port using a req/ready handshake, so memory may insert wait states.
Adds a configurable register count (RV32I/RV32E), a configurable reset PC, illegal-instruction halt, retire pulse and a debug register read port.
Supported instructions: add, sub, and, or, slt, addi, lw, sw, beq, jal.

Parameters:
NREGS, 32, architectural register count; legal values 32 or 16 (RV32E).
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
mem_req  out  1  memory transfer request
mem_we  out  1  1 = store, 0 = load/fetch
mem_addr  out  32  byte address (word aligned for fetch and lw/sw)
mem_wdata  out  32  store data
mem_rdata  in  32  read data; valid in the cycle mem_ready=1
mem_ready  in  1  transfer completes on a rising edge where mem_req=1 and mem_ready=1
pc  out  32  current instruction address
retire  out  1  one-cycle pulse in the final state of each completed instruction
halted  out  1  sticky, set on illegal instruction
dbg_addr  in  5  debug register index
dbg_data  out  32  combinational read of x[dbg_addr]; 0 for x0 or index >= NREGS

Behaviour:
- Reset (async) sets:
  - state=FETCH, pc=RESET_PC, IR=0, all registers=0, halted=0.
  - mem_req, mem_we and retire are forced 0 while reset is high.
- Reset mid-transfer abandons the transfer. No retire is produced.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=pc.
  - Stays in FETCH while mem_ready=0.
  - On ready: IR<=mem_rdata, go to DECODE.
- DECODE:
  - Latches A<=x[rs1], B<=x[rs2], imm<=sign-extended immediate (I/S/B/J forms).
  - Unknown opcode/funct, or any of rd/rs1/rs2 >= NREGS, goes to HALT.
- EXEC:
  - R-type/addi: ALUOut<=A op (B|imm); go to WB.
  - lw/sw: ALUOut<=A+imm; go to MEM.
  - beq: if A==B then pc<=pc+imm, else pc<=pc+4. Assert retire, go to FETCH.
  - jal: ALUOut<=pc+4, pc<=pc+imm; go to WB.
- MEM:
  - Drives mem_req=1, mem_addr=ALUOut, mem_we=sw, mem_wdata=B.
  - Holds addr/we/wdata stable until ready.
  - On ready: lw latches MDR<=mem_rdata and goes to WB; sw sets pc<=pc+4, asserts retire, goes to FETCH.
- WB:
  - Writes x[rd]<=(lw ? MDR : ALUOut). Writes to x0 are discarded.
  - Non-jal instructions set pc<=pc+4 (jal already updated pc in EXEC).
  - Asserts retire, goes to FETCH.
- HALT: absorbing until reset. halted=1, mem_req=0, pc frozen at the faulting instruction.
- Cycle counts with zero wait states:
  - beq 3 cycles.
  - R-type, addi, sw, jal 4 cycles.
  - lw 5 cycles.
  - Each wait cycle adds 1.
- Arithmetic:
  - All ALU operations are 32-bit modulo 2^32, wrapping silently.
  - slt is a signed compare producing 0 or 1.
  - pc+imm wraps modulo 2^32.
- mem_ready while mem_req=0 is ignored.
- mem_rdata is sampled only on a completing edge.
- dbg_data reflects a register write from the cycle after the WB edge.

Test Plan:
- Reset/first fetch:
  - Hold reset 3 cycles with RESET_PC=32'h100, then release.
  - Required: mem_req=1, mem_addr=32'h100 in the first cycle; mem_req=0 during reset.
- ALU sequence, zero wait:
  - Program 0x00500093 (addi x1,x0,5) then 0x00108133 (add x2,x1,x1).
  - Required: dbg x1=5, x2=10; retire every 4 cycles; pc=8 after both.
- Memory with 2 wait states:
  - Program 0x00202423 (sw x2,8(x0)) with x2=10, then 0x00802183 (lw x3,8(x0)).
  - Required: store at addr 8 with wdata=10 held stable through the waits; x3=10.
  - Required: lw takes 5+2 cycles (plus fetch waits).
- Branch loop:
  - 0xFE000EE3 (beq x0,x0,-4) at pc=4.
  - Required: pc=0 next and retire after 3 cycles.
  - Also test an x0 write: 0x00500013 (addi x0,x0,5) leaves x0=0.
- Illegal/RV32E:
  - Fetch 0x00000000: required HALT, halted=1, mem_req=0 forever, pc unchanged.
  - With NREGS=16, fetch 0x01000893 (rd=17): required HALT.
- Reset mid-MEM:
  - Assert reset while a lw is waiting with mem_ready=0.
  - Required: immediate mem_req=0, pc=RESET_PC, no retire, x3 unchanged before reset clears registers.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I-subset core with a unified req/ready memory port.
// Sequencer FSM steps FETCH/DECODE/EXEC/MEM/WB; illegal encodings park in HALT.
module multicycle_datapath #(
  parameter int          NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
    OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JAL,
    OP_BAD
  } op_t;

  localparam int          RW = $clog2(NREGS);
  localparam logic [5:0]  NR = 6'(NREGS);

  state_t      state, state_n;
  op_t         op;
  logic [31:0] ir, a_q, b_q, imm_q, alu_q, mdr_q;
  logic [31:0] regs [NREGS];

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic        use_rd, use_rs1, use_rs2, bad_reg;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm;

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  function automatic logic [31:0] rf_rd(
    input logic [4:0] idx
  );
    if (idx == 5'd0 || {1'b0, idx} >= NR)
      return 32'd0;
    return regs[idx[RW-1:0]];
  endfunction

  logic is_r;
  assign is_r = (opc == 7'b0110011);

  always_comb begin
    op = OP_BAD;
    unique case (1'b1)
      is_r && f7 == 7'h00 && f3 == 3'd0: op = OP_ADD;
      is_r && f7 == 7'h20 && f3 == 3'd0: op = OP_SUB;
      is_r && f7 == 7'h00 && f3 == 3'd7: op = OP_AND;
      is_r && f7 == 7'h00 && f3 == 3'd6: op = OP_OR;
      is_r && f7 == 7'h00 && f3 == 3'd2: op = OP_SLT;
      opc == 7'b0010011 && f3 == 3'd0:   op = OP_ADDI;
      opc == 7'b0000011 && f3 == 3'd2:   op = OP_LW;
      opc == 7'b0100011 && f3 == 3'd2:   op = OP_SW;
      opc == 7'b1100011 && f3 == 3'd0:   op = OP_BEQ;
      opc == 7'b1101111:                 op = OP_JAL;
      default:                           op = OP_BAD;
    endcase
  end

  // Only register fields the instruction actually uses are range-checked
  always_comb begin
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm     = imm_i;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_SW: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = imm_s;
      end
      OP_BEQ: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = imm_b;
      end
      OP_JAL: begin
        use_rd = 1'b1;
        imm    = imm_j;
      end
      default: ;
    endcase
  end

  assign bad_reg = (use_rd  && {1'b0, rd}  >= NR) ||
                   (use_rs1 && {1'b0, rs1} >= NR) ||
                   (use_rs2 && {1'b0, rs2} >= NR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= FETCH;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    mem_wdata = b_q;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready)
          state_n = DECODE;
      end
      DECODE: begin
        if (op == OP_BAD || bad_reg)
          state_n = HALT;
        else
          state_n = EXEC;
      end
      EXEC: begin
        if (op == OP_BEQ) begin
          retire  = 1'b1;
          state_n = FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_n = MEM;
        end else begin
          state_n = WB;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_addr = alu_q;
        mem_we   = (op == OP_SW);
        if (mem_ready) begin
          if (op == OP_LW) begin
            state_n = WB;
          end else begin
            retire  = 1'b1;
            state_n = FETCH;
          end
        end
      end
      WB: begin
        retire  = 1'b1;
        state_n = FETCH;
      end
      default: state_n = HALT;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
    end
  end

  assign halted = (state == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready)
            ir <= mem_rdata;
        end
        DECODE: begin
          a_q   <= rf_rd(rs1);
          b_q   <= rf_rd(rs2);
          imm_q <= imm;
        end
        EXEC: begin
          case (op)
            OP_ADD:  alu_q <= a_q + b_q;
            OP_SUB:  alu_q <= a_q - b_q;
            OP_AND:  alu_q <= a_q & b_q;
            OP_OR:   alu_q <= a_q | b_q;
            OP_SLT:  alu_q <= {31'd0,
                      $signed(a_q) < $signed(b_q)};
            OP_ADDI,
            OP_LW,
            OP_SW:   alu_q <= a_q + imm_q;
            OP_BEQ:  pc <= (a_q == b_q) ?
                      pc + imm_q : pc + 32'd4;
            OP_JAL: begin
              alu_q <= pc + 32'd4;
              pc    <= pc + imm_q;
            end
            default: ;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (op == OP_LW)
              mdr_q <= mem_rdata;
            else
              pc <= pc + 32'd4;
          end
        end
        WB: begin
          if (rd != 5'd0)
            regs[rd[RW-1:0]] <=
              (op == OP_LW) ? mdr_q : alu_q;
          // jal already redirected pc in EXEC
          if (op != OP_JAL)
            pc <= pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

  assign dbg_data = rf_rd(dbg_addr);

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench: an instruction-level model predicts retires and bus
// traffic; monitor and memory processes pop and compare.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc, dbg_data;
  logic        retire, halted;
  logic [4:0]  dbg_addr, dbg_mon, dbg_stim;
  logic        dbg_sel;

  assign dbg_addr = dbg_sel ? dbg_stim : dbg_mon;

  multicycle_datapath #(
    .NREGS(32), .RESET_PC(32'h100)
  ) u_dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .retire(retire), .halted(halted),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  logic        e_reset, e_req, e_we, e_ret, e_halt;
  logic [31:0] e_addr, e_wdata, e_rdata, e_pc, e_dbg;
  logic [4:0]  e_dbg_addr;
  logic        e_ready;
  int          e_ret_n = 0;

  assign e_ready = 1'b1;
  assign e_rdata = (e_addr == 32'h0) ?
                   32'h00300793 : 32'h01000893;

  multicycle_datapath #(
    .NREGS(16), .RESET_PC(32'h0)
  ) u_e (
    .clk(clk), .reset(e_reset),
    .mem_req(e_req), .mem_we(e_we),
    .mem_addr(e_addr), .mem_wdata(e_wdata),
    .mem_rdata(e_rdata), .mem_ready(e_ready),
    .pc(e_pc), .retire(e_ret), .halted(e_halt),
    .dbg_addr(e_dbg_addr), .dbg_data(e_dbg)
  );

  typedef struct {
    logic [31:0] npc;
    logic [4:0]  ri;
    logic [31:0] rv;
    int          cyc;
  } ev_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  ev_t         exp_q[$];
  bus_t        bus_q[$];
  int          pass_n = 0;
  int          total_n = 0;
  int          wait_n = 0;
  bit          stall = 1'b0;
  logic [31:0] halt_pc;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h, want %h",
                  nm, act, exp);
  endtask

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [2:0] f3,
    input logic [4:0] rd, rs1, rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [6:0] o, input logic [2:0] f3,
    input logic [4:0] rd, rs1, input logic [11:0] im);
    return {im, rs1, f3, rd, o};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [4:0] rs1, rs2, input logic [11:0] im);
    return {im[11:5], rs2, rs1, 3'b010,
            im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [4:0] rs1, rs2, input logic [12:0] im);
    return {im[12], im[10:5], rs2, rs1, 3'b000,
            im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [4:0] rd, input logic [20:0] im);
    return {im[20], im[10:1], im[11], im[19:12],
            rd, 7'b1101111};
  endfunction

  // Instruction-set model: runs the program to completion up front
  task automatic iss();
    logic [31:0] x [32];
    logic [31:0] p, w, a, b, val, np, ad;
    logic [31:0] ii, si, bi, ji;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  o, f7;
    bit          wr, done;
    int          cyc, ri;
    for (int i = 0; i < 32; i++) x[i] = 0;
    p = 32'h100;
    done = 0;
    for (int s = 0; s < 2000 && !done; s++) begin
      w = ref_mem[p[11:2]];
      bus_q.push_back('{1'b0, p, 32'h0});
      o = w[6:0]; rd = w[11:7]; f3 = w[14:12];
      rs1 = w[19:15]; rs2 = w[24:20]; f7 = w[31:25];
      ii = {{20{w[31]}}, w[31:20]};
      si = {{20{w[31]}}, w[31:25], w[11:7]};
      bi = {{19{w[31]}}, w[31], w[7], w[30:25],
            w[11:8], 1'b0};
      ji = {{11{w[31]}}, w[31], w[19:12], w[20],
            w[30:21], 1'b0};
      a = x[rs1]; b = x[rs2];
      wr = 1; val = 0; np = p + 4; cyc = 4 + wait_n;
      if (o == 7'h33 && f3 == 0 && f7 == 0)
        val = a + b;
      else if (o == 7'h33 && f3 == 0 && f7 == 7'h20)
        val = a - b;
      else if (o == 7'h33 && f3 == 7 && f7 == 0)
        val = a & b;
      else if (o == 7'h33 && f3 == 6 && f7 == 0)
        val = a | b;
      else if (o == 7'h33 && f3 == 2 && f7 == 0)
        val = ($signed(a) < $signed(b)) ? 1 : 0;
      else if (o == 7'h13 && f3 == 0)
        val = a + ii;
      else if (o == 7'h03 && f3 == 2) begin
        ad = a + ii;
        val = ref_mem[ad[11:2]];
        bus_q.push_back('{1'b0, ad, 32'h0});
        cyc = 5 + 2 * wait_n;
      end else if (o == 7'h23 && f3 == 2) begin
        ad = a + si;
        ref_mem[ad[11:2]] = b;
        bus_q.push_back('{1'b1, ad, b});
        wr = 0;
        cyc = 4 + 2 * wait_n;
      end else if (o == 7'h63 && f3 == 0) begin
        wr = 0;
        np = (a == b) ? p + bi : p + 4;
        cyc = 3 + wait_n;
      end else if (o == 7'h6f) begin
        val = p + 4;
        np = p + ji;
      end else begin
        halt_pc = p;
        done = 1;
      end
      if (!done) begin
        if (wr && rd != 0) x[rd] = val;
        ri = wr ? int'(rd) : $urandom_range(0, 31);
        exp_q.push_back('{np, 5'(ri), x[ri], cyc});
        p = np;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, r1, r2;
    logic [11:0] im;
    int          k;
    k  = $urandom_range(0, 9);
    rd = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    im = 12'(32'h400 + 4 * $urandom_range(0, 255));
    case (k)
      0: return enc_r(7'h00, 3'd0, rd, r1, r2);
      1: return enc_r(7'h20, 3'd0, rd, r1, r2);
      2: return enc_r(7'h00, 3'd7, rd, r1, r2);
      3: return enc_r(7'h00, 3'd6, rd, r1, r2);
      4: return enc_r(7'h00, 3'd2, rd, r1, r2);
      5: return enc_i(7'h13, 3'd0, rd, r1,
                      12'($urandom));
      6: return enc_i(7'h03, 3'd2, rd, 5'd0, im);
      7: return enc_s(5'd0, r2, im);
      8: return enc_b(r1 & 5'd3, r2 & 5'd3,
                      $urandom_range(0, 1) ?
                      13'd8 : 13'd12);
      default: return enc_j(rd, 21'd8);
    endcase
  endfunction

  task automatic gen_prog();
    for (int i = 0; i < 1024; i++)
      mem[i] = (i >= 256 && i < 512) ? $urandom : 0;
    for (int i = 0; i < 40; i++)
      mem[64 + i] = rand_instr();
  endtask

  task automatic load_directed();
    for (int i = 0; i < 1024; i++) mem[i] = 0;
    mem[64] = 32'h00500093;
    mem[65] = 32'h00108133;
    mem[66] = 32'h00202423;
    mem[67] = 32'h00802183;
    mem[68] = 32'h00500013;
    mem[69] = enc_j(5'd0, 21'd8);
    mem[70] = enc_j(5'd0, 21'd8);
    mem[71] = 32'hFE000EE3;
    mem[72] = enc_r(7'h20, 3'd0, 5'd4, 5'd0, 5'd1);
    mem[73] = enc_r(7'h00, 3'd2, 5'd5, 5'd4, 5'd1);
    mem[74] = enc_r(7'h00, 3'd2, 5'd6, 5'd1, 5'd4);
    mem[75] = enc_r(7'h00, 3'd7, 5'd7, 5'd4, 5'd2);
    mem[76] = enc_r(7'h00, 3'd6, 5'd8, 5'd4, 5'd2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_prog();
    tick();
    reset = 1'b1;
    exp_q.delete();
    bus_q.delete();
    ref_mem = mem;
    iss();
    repeat (3) begin
      tick();
      chk("reset req", 32'(mem_req), 0);
      chk("reset retire", 32'(retire), 0);
    end
    tick();
    reset = 1'b0;
    #1;
    chk("first fetch req", 32'(mem_req), 1);
    chk("first fetch addr", mem_addr, 32'h100);
    for (int c = 0; c < 20000 && !halted; c++)
      @(negedge clk);
    chk("halt reached", 32'(halted), 1);
    chk("halt pc", pc, halt_pc);
    repeat (3) begin
      @(negedge clk);
      chk("halt req", 32'(mem_req), 0);
    end
    chk("halt pc frozen", pc, halt_pc);
    chk("retires left", exp_q.size(), 0);
    chk("bus left", bus_q.size(), 0);
  endtask

  initial begin : monitor
    int          cnt;
    bit          pend;
    logic [31:0] ppc, pval;
    ev_t         e;
    cnt = 0; pend = 0; dbg_mon = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
        pend = 0;
      end else begin
        if (pend) begin
          chk("next pc", pc, ppc);
          chk("reg value", dbg_data, pval);
          pend = 0;
        end
        cnt++;
        if (retire) begin
          if (exp_q.size() == 0) begin
            total_n++;
            $display("FAIL retire: got retire at pc %h, want none",
                     pc);
          end else begin
            e = exp_q.pop_front();
            chk("retire cycles", cnt, e.cyc);
            cnt = 0;
            pend = 1;
            ppc = e.npc;
            pval = e.rv;
            dbg_mon = e.ri;
          end
        end
      end
    end
  end

  initial begin : memory
    int          wcnt, lim;
    bit          active;
    logic [31:0] la, ld;
    logic        lwe;
    bus_t        b;
    wcnt = 0; active = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        active = 0; wcnt = 0;
        mem_ready = 1'b0;
      end else if (!mem_req) begin
        active = 0; wcnt = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end else begin
        if (!active) begin
          active = 1;
          la = mem_addr; lwe = mem_we; ld = mem_wdata;
        end else begin
          chk("bus hold", 32'((mem_addr !== la) ||
              (mem_we !== lwe) ||
              (lwe && mem_wdata !== ld)), 0);
        end
        lim = (stall && mem_addr == 32'h400) ?
              1000000 : wait_n;
        if (wcnt >= lim) begin
          mem_ready = 1'b1;
          active = 0; wcnt = 0;
          if (bus_q.size() == 0) begin
            total_n++;
            $display("FAIL bus: got transfer at %h, want none",
                     mem_addr);
          end else begin
            b = bus_q.pop_front();
            chk("bus we", 32'(mem_we), 32'(b.we));
            chk("bus addr", mem_addr, b.addr);
            if (b.we) chk("bus wdata", mem_wdata, b.data);
          end
          if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
          mem_rdata = mem[mem_addr[11:2]];
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          wcnt++;
        end
      end
    end
  end

  always @(negedge clk)
    if (!e_reset && e_ret) e_ret_n++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    e_reset = 1'b1;
    dbg_sel = 1'b0;
    dbg_stim = 5'd0;
    e_dbg_addr = 5'd15;
    tick();
    e_reset = 1'b0;
    load_directed();
    wait_n = 0;
    run_prog();
    chk("mem[8] stored", mem[2], 32'd10);
    load_directed();
    wait_n = 2;
    run_prog();
    for (int r = 0; r < 3; r++) begin
      gen_prog();
      wait_n = $urandom_range(0, 3);
      run_prog();
    end

    chk("e halted", 32'(e_halt), 1);
    chk("e pc", e_pc, 32'h4);
    chk("e req", 32'(e_req), 0);
    chk("e retires", e_ret_n, 1);
    #1;
    chk("e x15", e_dbg, 32'd3);
    e_dbg_addr = 5'd17;
    #1;
    chk("e x17", e_dbg, 32'd0);

    for (int i = 0; i < 1024; i++) mem[i] = 0;
    mem[64] = enc_i(7'h13, 3'd0, 5'd3, 5'd0, 12'd7);
    mem[65] = enc_i(7'h03, 3'd2, 5'd3, 5'd0, 12'h400);
    mem[256] = 32'd99;
    wait_n = 0;
    stall = 1'b1;
    tick();
    reset = 1'b1;
    exp_q.delete();
    bus_q.delete();
    bus_q.push_back('{1'b0, 32'h100, 32'h0});
    bus_q.push_back('{1'b0, 32'h104, 32'h0});
    exp_q.push_back('{32'h104, 5'd3, 32'd7, 4});
    repeat (3) tick();
    reset = 1'b0;
    for (int c = 0; c < 200 &&
         !(mem_req && mem_addr == 32'h400); c++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    chk("lw waiting", mem_addr, 32'h400);
    chk("lw req", 32'(mem_req), 1);
    chk("addi retired", exp_q.size(), 0);
    dbg_sel = 1'b1;
    dbg_stim = 5'd3;
    #1;
    chk("x3 before reset", dbg_data, 32'd7);
    tick();
    reset = 1'b1;
    #1;
    chk("abort req", 32'(mem_req), 0);
    chk("abort retire", 32'(retire), 0);
    chk("abort pc", pc, 32'h100);
    chk("abort x3", dbg_data, 32'd0);
    repeat (2) tick();
    chk("abort bus left", bus_q.size(), 0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
